prefetch_rd_pipe: RTL and testbench



---
 rtl/prefetch_rd_pipe.sv | 118 +++++++++++
 tb/tb_prefetch_rd_pipe.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_rd_pipe.sv
// prefetch_rd_pipe: read-side prefetch engine for the FIFO family.
// Issues RAM reads ahead of the consumer into a small circular
// first-word-fall-through buffer, hiding RAM_LATENCY so a valid/ready
// consumer can take one word per cycle. A synchronous flush drops every
// buffered and in-flight word.
// Optional feature macro: PREFETCH_LEVEL_EN adds the registered rd_level port
// (stored + in-flight words).
module prefetch_rd_pipe #(
   parameter int DATA_WIDTH     = 32,
   parameter int RAM_LATENCY    = 1,
   parameter int PREFETCH_DEPTH = 4
) (
   input  logic                  rd_clk,
   input  logic                  rd_rst,
   input  logic                  fifo_empty,
   output logic                  ram_rd_en,
   input  logic [DATA_WIDTH-1:0] ram_rd_data,
   input  logic                  flush,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_vld,
   input  logic                  rd_en
`ifdef PREFETCH_LEVEL_EN
   ,
   output logic [$clog2(PREFETCH_DEPTH+1)-1:0] rd_level
`endif
);

   localparam int CW = $clog2(PREFETCH_DEPTH + 1);
   localparam int PW = $clog2(PREFETCH_DEPTH);
   localparam logic [PW-1:0] PTR_MAX = PW'(PREFETCH_DEPTH - 1);
   localparam logic [CW:0]   OCC_MAX = (CW+1)'(PREFETCH_DEPTH);

   // Illegal configurations stop elaboration.
   generate
      if (DATA_WIDTH < 1 || DATA_WIDTH > 1152) begin : g_bad_width
         $error("prefetch_rd_pipe: DATA_WIDTH must be 1..1152");
      end
      if (RAM_LATENCY < 1 || RAM_LATENCY > 3) begin : g_bad_lat
         $error("prefetch_rd_pipe: RAM_LATENCY must be 1..3");
      end
      if (PREFETCH_DEPTH < 2 || PREFETCH_DEPTH > 16 ||
          PREFETCH_DEPTH < RAM_LATENCY + 1) begin : g_bad_depth
         $error("prefetch_rd_pipe: PREFETCH_DEPTH must be 2..16 and >= RAM_LATENCY+1");
      end
   endgenerate

   logic [CW-1:0]          stored;
   logic [RAM_LATENCY-1:0] ifl;       // one bit per issued, not-yet-arrived read
   logic [PW-1:0]          wr_ptr;
   logic [PW-1:0]          rd_ptr;
   logic [DATA_WIDTH-1:0]  mem [PREFETCH_DEPTH];

   logic          pop;
   logic          cap;
   logic [CW-1:0] ifl_cnt;
   logic [CW:0]   occ;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PTR_MAX) ? '0 : p + 1'b1;
   endfunction

   // Occupancy, handshake and read-issue decision.
   always_comb begin
      ifl_cnt = '0;
      for (int i = 0; i < RAM_LATENCY; i++) ifl_cnt = ifl_cnt + CW'(ifl[i]);
      occ     = {1'b0, stored} + {1'b0, ifl_cnt};
      rd_vld  = (stored != '0);
      rd_data = mem[rd_ptr];
      pop     = rd_vld & rd_en & ~flush;
      // A word landing in the flush cycle is dropped along with the rest.
      cap     = ifl[RAM_LATENCY-1] & ~flush;
      // A same-cycle pop frees the slot the new read will eventually use.
      ram_rd_en = ~rd_rst & ~fifo_empty & ~flush & ((occ < OCC_MAX) | pop);
   end

   // In-flight shift register: bit0 records this cycle's issue.
   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst)     ifl <= '0;
      else if (flush) ifl <= '0;
      else            ifl <= (ifl << 1) | RAM_LATENCY'(ram_rd_en);
   end

   // Stored count and circular buffer pointers.
   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         stored <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         stored <= '0;
         rd_ptr <= wr_ptr;
      end else begin
         if (cap && !pop)      stored <= stored + 1'b1;
         else if (!cap && pop) stored <= stored - 1'b1;
         if (cap) wr_ptr <= ptr_inc(wr_ptr);
         if (pop) rd_ptr <= ptr_inc(rd_ptr);
      end
   end

   // Buffer storage: arriving RAM words land at wr_ptr.
   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         for (int i = 0; i < PREFETCH_DEPTH; i++) mem[i] <= '0;
      end else if (cap) begin
         mem[wr_ptr] <= ram_rd_data;
      end
   end

`ifdef PREFETCH_LEVEL_EN
   // Level tracks stored + in-flight; an arrival only moves a word between the two.
   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst)     rd_level <= '0;
      else if (flush) rd_level <= '0;
      else            rd_level <= rd_level + CW'(ram_rd_en) - CW'(pop);
   end
`endif

endmodule

// File: tb/tb_prefetch_rd_pipe.sv
// Bench for prefetch_rd_pipe: two instances (RAM_LATENCY 1 and 3, depth 4),
// each fed by a RAM model returning an incrementing sequence, and a queue
// scoreboard of issued words used for the randomized run.
module tb_prefetch_rd_pipe;

   localparam int D = 4;

   typedef struct {
      logic [31:0] v;
      int          rdy;
   } item_t;

   logic             rd_clk = 1'b0;
   logic             rd_rst = 1'b1;
   logic [1:0]       fifo_empty = '1;
   logic [1:0]       flush = '0;
   logic [1:0]       rd_en = '0;
   logic [1:0]       ram_rd_en;
   logic [1:0]       rd_vld;
   logic [1:0][31:0] ram_rd_data;
   logic [1:0][31:0] rd_data;
`ifdef PREFETCH_LEVEL_EN
   logic [1:0][2:0]  rd_level;
`endif

   // model outputs per instance
   logic [1:0]       exp_vld;
   logic [1:0]       exp_en;
   logic [1:0][31:0] exp_data;
   logic [1:0][31:0] nv;
   logic [1:0][7:0]  exp_n;

   int cmp = 0;
   int err = 0;

   initial forever #5 rd_clk = ~rd_clk;

   prefetch_rd_pipe #(.DATA_WIDTH(32), .RAM_LATENCY(1), .PREFETCH_DEPTH(D)) u_a (
      .rd_clk(rd_clk), .rd_rst(rd_rst), .fifo_empty(fifo_empty[0]),
      .ram_rd_en(ram_rd_en[0]), .ram_rd_data(ram_rd_data[0]), .flush(flush[0]),
      .rd_data(rd_data[0]), .rd_vld(rd_vld[0]), .rd_en(rd_en[0])
`ifdef PREFETCH_LEVEL_EN
      , .rd_level(rd_level[0])
`endif
   );

   prefetch_rd_pipe #(.DATA_WIDTH(32), .RAM_LATENCY(3), .PREFETCH_DEPTH(D)) u_b (
      .rd_clk(rd_clk), .rd_rst(rd_rst), .fifo_empty(fifo_empty[1]),
      .ram_rd_en(ram_rd_en[1]), .ram_rd_data(ram_rd_data[1]), .flush(flush[1]),
      .rd_data(rd_data[1]), .rd_vld(rd_vld[1]), .rd_en(rd_en[1])
`ifdef PREFETCH_LEVEL_EN
      , .rd_level(rd_level[1])
`endif
   );

   // RAM model and scoreboard, one per instance.
   for (genvar k = 0; k < 2; k++) begin : g_mdl
      localparam int L = (k == 0) ? 1 : 3;
      item_t       q[$];
      int          cyc = 0;
      logic [31:0] cnt = 32'd1;
      logic [31:0] pipe [L];
      logic        vld_m = 1'b0;
      logic [31:0] dat_m = '0;
      int          n_m = 0;

      // RAM: returns cnt L cycles after each issue, junk otherwise.
      always @(posedge rd_clk) begin
         pipe[0] <= ram_rd_en[k] ? cnt : (32'hDEAD_0000 | 32'($urandom_range(0, 255)));
         for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
         if (ram_rd_en[k]) cnt <= cnt + 32'd1;
      end

      // Scoreboard: every issued word is owed to the consumer, in order,
      // visible from L+1 cycles after issue, unless flushed or reset first.
      always @(posedge rd_clk) begin
         logic pop_m;
         pop_m = vld_m & rd_en[k] & ~flush[k];
         if (rd_rst || flush[k]) q.delete();
         else begin
            if (pop_m && q.size() > 0) void'(q.pop_front());
            if (ram_rd_en[k]) q.push_back('{v: cnt, rdy: cyc + L + 1});
         end
         cyc   = cyc + 1;
         vld_m = (q.size() > 0) && (q[0].rdy <= cyc);
         dat_m = (q.size() > 0) ? q[0].v : '0;
         n_m   = q.size();
      end

      assign ram_rd_data[k] = pipe[L-1];
      assign exp_vld[k]  = vld_m & ~rd_rst;
      assign exp_data[k] = dat_m;
      assign nv[k]       = cnt;
      assign exp_n[k]    = 8'(n_m);
      assign exp_en[k]   = ~rd_rst & ~fifo_empty[k] & ~flush[k] &
                           ((n_m < D) | (exp_vld[k] & rd_en[k]));
   end

   task automatic cyc_step();
      @(posedge rd_clk);
      #1;
   endtask

   task automatic drain(input int k);
      fifo_empty[k] = 1'b1;
      flush[k]      = 1'b0;
      rd_en[k]      = 1'b1;
      repeat (10) cyc_step();
      rd_en[k]      = 1'b0;
   endtask

   task automatic test_reset();
      fifo_empty = '0;
      repeat (3) cyc_step();
      @(negedge rd_clk);
      for (int k = 0; k < 2; k++) begin
         cmp++; if (rd_vld[k] !== 1'b0) begin err++; $display("FAIL reset_vld[%0d] got %b want 0", k, rd_vld[k]); end
         cmp++; if (rd_data[k] !== 32'h0) begin err++; $display("FAIL reset_data[%0d] got %h want 0", k, rd_data[k]); end
         cmp++; if (ram_rd_en[k] !== 1'b0) begin err++; $display("FAIL reset_ram_rd_en[%0d] got %b want 0", k, ram_rd_en[k]); end
      end
      fifo_empty = '1;
      @(posedge rd_clk); #1;
      rd_rst = 1'b0;
      cyc_step();
   endtask

   task automatic test_stream();
      logic [31:0] base;
      base = nv[0];
      fifo_empty[0] = 1'b0;
      rd_en[0]      = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge rd_clk);
         if (c == 0) begin
            cmp++; if (ram_rd_en[0] !== 1'b1) begin err++; $display("FAIL stream_issue got %b want 1", ram_rd_en[0]); end
         end
         cmp++; if (rd_vld[0] !== (c >= 2)) begin err++; $display("FAIL stream_vld c%0d got %b want %b", c, rd_vld[0], c >= 2); end
         if (c >= 2) begin
            cmp++; if (rd_data[0] !== base + 32'(c - 2)) begin err++; $display("FAIL stream_data c%0d got %h want %h", c, rd_data[0], base + 32'(c - 2)); end
         end
         cyc_step();
      end
      drain(0);
   endtask

   task automatic test_backpressure();
      logic [31:0] base;
      int          pulses;
      base   = nv[1];
      pulses = 0;
      fifo_empty[1] = 1'b0;
      rd_en[1]      = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(negedge rd_clk);
         if (ram_rd_en[1]) pulses++;
         cyc_step();
      end
      @(negedge rd_clk);
      cmp++; if (pulses != D) begin err++; $display("FAIL bp_pulses got %0d want %0d", pulses, D); end
      cmp++; if (ram_rd_en[1] !== 1'b0) begin err++; $display("FAIL bp_hold got %b want 0", ram_rd_en[1]); end
      cmp++; if (rd_vld[1] !== 1'b1 || rd_data[1] !== base) begin err++; $display("FAIL bp_head got %b/%h want 1/%h", rd_vld[1], rd_data[1], base); end
`ifdef PREFETCH_LEVEL_EN
      cmp++; if (rd_level[1] !== 3'(D)) begin err++; $display("FAIL bp_level got %0d want %0d", rd_level[1], D); end
`endif
      cyc_step();
      rd_en[1] = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge rd_clk);
         if (c == 0) begin
            cmp++; if (ram_rd_en[1] !== 1'b1) begin err++; $display("FAIL bp_resume got %b want 1", ram_rd_en[1]); end
         end
         cmp++; if (rd_vld[1] !== 1'b1 || rd_data[1] !== base + 32'(c)) begin
            err++; $display("FAIL bp_stream c%0d got %b/%h want 1/%h", c, rd_vld[1], rd_data[1], base + 32'(c));
         end
         cyc_step();
      end
      drain(1);
   endtask

   task automatic test_wrap();
      logic [31:0] base;
      base = nv[0];
      fifo_empty[0] = 1'b0;
      rd_en[0]      = 1'b0;
      repeat (6) cyc_step();
      rd_en[0] = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge rd_clk);
         cmp++; if (rd_vld[0] !== 1'b1 || rd_data[0] !== base + 32'(c)) begin
            err++; $display("FAIL wrap_data c%0d got %b/%h want 1/%h", c, rd_vld[0], rd_data[0], base + 32'(c));
         end
`ifdef PREFETCH_LEVEL_EN
         cmp++; if (rd_level[0] !== 3'(D)) begin err++; $display("FAIL wrap_level c%0d got %0d want %0d", c, rd_level[0], D); end
`endif
         cyc_step();
      end
      drain(0);
   endtask

   task automatic test_flush();
      logic [31:0] base;
      bit          found;
      base  = nv[1];
      found = 1'b0;
      fifo_empty[1] = 1'b0;
      rd_en[1]      = 1'b0;
      repeat (4) cyc_step();          // four reads issued in cycles 0..3
      fifo_empty[1] = 1'b1;
      cyc_step();                     // cycle 5: 2 stored, 2 in flight
      flush[1]      = 1'b1;
      fifo_empty[1] = 1'b0;
      rd_en[1]      = 1'b1;
      @(negedge rd_clk);
      cmp++; if (rd_vld[1] !== 1'b1 || rd_data[1] !== base) begin err++; $display("FAIL flush_pre got %b/%h want 1/%h", rd_vld[1], rd_data[1], base); end
      cmp++; if (ram_rd_en[1] !== 1'b0) begin err++; $display("FAIL flush_issue got %b want 0", ram_rd_en[1]); end
`ifdef PREFETCH_LEVEL_EN
      cmp++; if (rd_level[1] !== 3'(D)) begin err++; $display("FAIL flush_level got %0d want %0d", rd_level[1], D); end
`endif
      cyc_step();
      flush[1] = 1'b0;
      for (int i = 0; i < 12 && !found; i++) begin
         @(negedge rd_clk);
         if (i == 0) begin
            cmp++; if (rd_vld[1] !== 1'b0) begin err++; $display("FAIL flush_vld got %b want 0", rd_vld[1]); end
            cmp++; if (ram_rd_en[1] !== 1'b1) begin err++; $display("FAIL flush_resume got %b want 1", ram_rd_en[1]); end
         end
         if (rd_vld[1]) begin
            found = 1'b1;
            cmp++; if (rd_data[1] !== base + 32'd4 || i != 4) begin
               err++; $display("FAIL flush_next got %h at +%0d want %h at +4", rd_data[1], i, base + 32'd4);
            end
         end
         cyc_step();
      end
      if (!found) begin
         cmp++; err++; $display("FAIL flush_timeout got no word want %h", base + 32'd4);
      end
      drain(1);
   endtask

   task automatic test_reset_mid();
      fifo_empty[0] = 1'b0;
      rd_en[0]      = 1'b1;
      repeat (5) cyc_step();
      @(negedge rd_clk);
      cmp++; if (rd_vld[0] !== 1'b1) begin err++; $display("FAIL rstmid_pre got %b want 1", rd_vld[0]); end
      rd_rst = 1'b1;
      #1;
      cmp++; if (rd_vld[0] !== 1'b0 || rd_data[0] !== 32'h0) begin err++; $display("FAIL rstmid_clear got %b/%h want 0/0", rd_vld[0], rd_data[0]); end
      cmp++; if (ram_rd_en[0] !== 1'b0) begin err++; $display("FAIL rstmid_issue got %b want 0", ram_rd_en[0]); end
      repeat (2) cyc_step();
      @(negedge rd_clk);
      cmp++; if (ram_rd_en[0] !== 1'b0) begin err++; $display("FAIL rstmid_hold got %b want 0", ram_rd_en[0]); end
      fifo_empty[0] = 1'b1;
      cyc_step();
      rd_rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge rd_clk);
         cmp++; if (rd_vld[0] !== 1'b0) begin err++; $display("FAIL rstmid_stale c%0d got %b want 0", c, rd_vld[0]); end
         cyc_step();
      end
      rd_en[0] = 1'b0;
   endtask

   task automatic test_random();
      for (int k = 0; k < 2; k++) begin
         for (int c = 0; c < 5000; c++) begin
            fifo_empty[k] = ($urandom_range(0, 99) < 30);
            rd_en[k]      = ($urandom_range(0, 99) < 60);
            flush[k]      = ($urandom_range(0, 99) < 3);
            @(negedge rd_clk);
            cmp++; if (rd_vld[k] !== exp_vld[k]) begin err++; $display("FAIL rnd_vld[%0d] c%0d got %b want %b", k, c, rd_vld[k], exp_vld[k]); end
            if (exp_vld[k]) begin
               cmp++; if (rd_data[k] !== exp_data[k]) begin err++; $display("FAIL rnd_data[%0d] c%0d got %h want %h", k, c, rd_data[k], exp_data[k]); end
            end
            cmp++; if (ram_rd_en[k] !== exp_en[k]) begin err++; $display("FAIL rnd_issue[%0d] c%0d got %b want %b", k, c, ram_rd_en[k], exp_en[k]); end
            cmp++; if (exp_n[k] > 8'(D)) begin err++; $display("FAIL rnd_occupancy[%0d] c%0d got %0d want <=%0d", k, c, exp_n[k], D); end
`ifdef PREFETCH_LEVEL_EN
            cmp++; if (rd_level[k] !== exp_n[k][2:0]) begin err++; $display("FAIL rnd_level[%0d] c%0d got %0d want %0d", k, c, rd_level[k], exp_n[k]); end
`endif
            cyc_step();
         end
         flush[k] = 1'b0;
         drain(k);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_wrap();
      test_flush();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
      $finish;
   end

endmodule
